// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//
// Instruction fetch stage of the cached single-cycle MIPS core. Owns the PC,
// fetches one instruction word at a time from the I-cache over a req/ready
// handshake and holds it for one execute cycle. During that cycle it presents
// opCode to the decoder and pcPlus4 to the datapath. At the end of the cycle it
// computes the next PC from the decoder's jump/branch outputs and the ALU zero
// flag.
//
// Sequencing: BOOT (one cycle after reset) -> FETCH (until icReady) -> EXEC
// (until coreStall is low at a clock edge) -> FETCH -> ...
// Best case is one instruction every two cycles.
//
// Ports
//   clk          in   core clock, all state updates on the rising edge
//   rst_n        in   asynchronous active-low reset
//   icReq        out  fetch request to the I-cache (high only in FETCH)
//   icAddr       out  fetch address, always equal to pc
//   icReady      in   I-cache returns data this cycle (looked at only in FETCH)
//   icRdata      in   instruction word, captured when icReq & icReady
//   jump         in   decoder jump control (used only in EXEC)
//   branch       in   decoder branch control (used only in EXEC)
//   zero         in   ALU zero flag (used only in EXEC)
//   coreStall    in   data-side miss; freezes the execute cycle
//   pc           out  address of the current instruction
//   pcPlus4      out  pc + 4, modulo 2^32
//   instr        out  held instruction word
//   opCode       out  instr[31:26]
//   instrValid   out  instr is in its execute cycle; gates architectural writes
//   retiredCount out  number of completed instructions, wraps
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // I-cache side
  output logic                 icReq,
  output logic [31:0]          icAddr,
  input  logic                 icReady,
  input  logic [31:0]          icRdata,
  // Control from decoder / ALU / data side
  input  logic                 jump,
  input  logic                 branch,
  input  logic                 zero,
  input  logic                 coreStall,
  // To decoder / datapath
  output logic [31:0]          pc,
  output logic [31:0]          pcPlus4,
  output logic [31:0]          instr,
  output logic [5:0]           opCode,
  output logic                 instrValid,
  output logic [CNT_WIDTH-1:0] retiredCount
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  // Architectural state
  state_t               state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [31:0]          instr_q, instr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Registered handshake/qualifier outputs. They are decoded from the next
  // state so they line up exactly with state_q, and the async reset clears
  // them immediately, which abandons any outstanding fetch request.
  logic                 ic_req_q;
  logic                 valid_q;

  // Next-PC datapath
  logic [31:0]          pc_plus4;
  logic [31:0]          jump_target;
  logic [31:0]          branch_offset;
  logic [31:0]          branch_target;
  logic [31:0]          next_pc;

  // Events
  logic                 fetch_done;
  logic                 retire;

  // ---------------------------------------------------------------------------
  // Next-PC computation (only consumed when an instruction retires)
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_plus4      = pc_q + 32'd4;
    // J-type: keep the region bits of pc+4, splice in the word index.
    jump_target   = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    // I-type branch: sign-extended word offset relative to pc+4.
    branch_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    branch_target = pc_plus4 + branch_offset;

    // Jump has priority over a taken branch when both are asserted.
    if (jump) begin
      next_pc = jump_target;
    end else if (branch && zero) begin
      next_pc = branch_target;
    end else begin
      next_pc = pc_plus4;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. jump/branch/zero/coreStall only matter in EXEC, and
  // icRdata is only captured on a completed handshake in FETCH.
  // ---------------------------------------------------------------------------
  always_comb begin
    fetch_done = (state_q == FETCH) && icReady;
    retire     = (state_q == EXEC) && !coreStall;

    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;

    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (fetch_done) begin
          instr_d = icRdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (retire) begin
          pc_d    = next_pc;
          cnt_d   = cnt_q + CNT_WIDTH'(1);
          state_d = FETCH;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      instr_q  <= 32'h0;
      cnt_q    <= '0;
      ic_req_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      cnt_q    <= cnt_d;
      ic_req_q <= (state_d == FETCH);
      valid_q  <= (state_d == EXEC);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign icReq        = ic_req_q;
  assign icAddr       = pc_q;
  assign pc           = pc_q;
  assign pcPlus4      = pc_plus4;
  assign instr        = instr_q;
  // Stale during FETCH; instrValid=0 tells the decoder to ignore it.
  assign opCode       = instr_q[31:26];
  assign instrValid   = valid_q;
  assign retiredCount = cnt_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// Testbench for inst_fetch_unit. The stimulus process pushes the expected
// fetch address and execute-cycle contents of each instruction into queues;
// an independent monitor pops and compares whenever the DUT starts a fetch
// (icReq rises) or enters an execute cycle (instrValid rises).
// The DUT uses a 4-bit counter so the wrap can be reached quickly.
// -----------------------------------------------------------------------------
module tb_inst_fetch_unit;

  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          icReq;
  logic [31:0]   icAddr;
  logic          icReady;
  logic [31:0]   icRdata;
  logic          jump;
  logic          branch;
  logic          zero;
  logic          coreStall;
  logic [31:0]   pc;
  logic [31:0]   pcPlus4;
  logic [31:0]   instr;
  logic [5:0]    opCode;
  logic          instrValid;
  logic [CW-1:0] retiredCount;

  inst_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .CNT_WIDTH(CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .icReq       (icReq),
    .icAddr      (icAddr),
    .icReady     (icReady),
    .icRdata     (icRdata),
    .jump        (jump),
    .branch      (branch),
    .zero        (zero),
    .coreStall   (coreStall),
    .pc          (pc),
    .pcPlus4     (pcPlus4),
    .instr       (instr),
    .opCode      (opCode),
    .instrValid  (instrValid),
    .retiredCount(retiredCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [3:0]  cnt;
  } exec_t;

  logic [31:0] exp_fetch[$];
  exec_t       exp_exec[$];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %h expected none", name, act);
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  initial begin
    logic prev_req;
    logic prev_vld;
    exec_t e;
    prev_req = 1'b0;
    prev_vld = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (icReq && !prev_req) begin
        if (exp_fetch.size() == 0) fail_now("fetch_unexpected", icAddr);
        else chk("fetch_addr", icAddr, exp_fetch.pop_front());
        $display("fetch  addr=%h", icAddr);
      end
      if (instrValid && !prev_vld) begin
        if (exp_exec.size() == 0) begin
          fail_now("exec_unexpected", pc);
        end else begin
          e = exp_exec.pop_front();
          chk("exec_pc", pc, e.pc);
          chk("exec_instr", instr, e.instr);
          chk("exec_pcplus4", pcPlus4, e.pc + 32'd4);
          chk("exec_opcode", {26'h0, opCode}, {26'h0, e.instr[31:26]});
          chk("exec_count", {28'h0, retiredCount}, {28'h0, e.cnt});
        end
        $display("exec   pc=%h instr=%h count=%0d", pc, instr, retiredCount);
      end
      prev_req = icReq;
      prev_vld = instrValid;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all called at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic fetch_phase(input logic [31:0] addr, input int miss);
    int n;
    n = 0;
    while (!icReq && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!icReq) fail_now("fetch_timeout", addr);
    for (int i = 0; i < miss; i++) begin
      icReady = 1'b0;
      icRdata = $urandom;
      @(negedge clk);
      chk("miss_hold_req", {31'h0, icReq}, 32'h1);
      chk("miss_hold_addr", icAddr, addr);
      chk("miss_no_valid", {31'h0, instrValid}, 32'h0);
    end
  endtask

  task automatic exec_phase(input logic [31:0] addr, input logic [31:0] word,
                            input logic j, input logic b, input logic z,
                            input int stall, input logic [3:0] cnt);
    icReady   = 1'b0;
    icRdata   = $urandom;
    jump      = j;
    branch    = b;
    zero      = z;
    coreStall = (stall > 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'h0, instrValid}, 32'h1);
      chk("stall_pc", pc, addr);
      chk("stall_instr", instr, word);
      chk("stall_count", {28'h0, retiredCount}, {28'h0, cnt});
      chk("stall_noreq", {31'h0, icReq}, 32'h0);
    end
    coreStall = 1'b0;
    @(negedge clk);
    // Now in FETCH: these inputs must be ignored here.
    jump      = 1'($urandom_range(0, 1));
    branch    = 1'($urandom_range(0, 1));
    zero      = 1'($urandom_range(0, 1));
    coreStall = 1'($urandom_range(0, 1));
  endtask

  task automatic do_instr(input logic [31:0] addr, input logic [31:0] word, input int miss,
                          input logic j, input logic b, input logic z,
                          input int stall, input logic [3:0] cnt);
    exec_t e;
    e.pc = addr;
    e.instr = word;
    e.cnt = cnt;
    exp_fetch.push_back(addr);
    exp_exec.push_back(e);
    fetch_phase(addr, miss);
    icReady = 1'b1;
    icRdata = word;
    @(negedge clk);
    exec_phase(addr, word, j, b, z, stall, cnt);
  endtask

  // Called at a falling edge with rst_n=0: releases reset and checks BOOT.
  task automatic boot(input logic [31:0] word);
    exec_t e;
    e.pc = 32'h0;
    e.instr = word;
    e.cnt = 4'd0;
    exp_fetch.push_back(32'h0);
    exp_exec.push_back(e);
    icReady = 1'b1;
    icRdata = word;
    rst_n   = 1'b1;
    #1;
    chk("boot_c1_noreq", {31'h0, icReq}, 32'h0);
    @(negedge clk);
    chk("boot_c2_req", {31'h0, icReq}, 32'h1);
    chk("boot_c2_addr", icAddr, 32'h0);
    @(negedge clk);
    chk("boot_c3_valid", {31'h0, instrValid}, 32'h1);
    chk("boot_c3_pc", pc, 32'h0);
    chk("boot_c3_pcplus4", pcPlus4, 32'h4);
    exec_phase(32'h0, word, 1'b0, 1'b0, 1'b0, 0, 4'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n     = 1'b0;
    icReady   = 1'b1;
    icRdata   = 32'h0;
    jump      = 1'b0;
    branch    = 1'b0;
    zero      = 1'b0;
    coreStall = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'h0, icReq}, 32'h0);
    chk("rst_valid", {31'h0, instrValid}, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_count", {28'h0, retiredCount}, 32'h0);

    // Boot + sequential ALU ops, 3-cycle miss on the second fetch.
    boot(32'h0128_4020);
    do_instr(32'h0000_0004, 32'h2108_0001, 3, 1'b0, 1'b0, 1'b0, 0, 4'd1);
    do_instr(32'h0000_0008, 32'h014B_4822, 0, 1'b0, 1'b0, 1'b0, 0, 4'd2);
    chk("count_after3", {28'h0, retiredCount}, 32'h3);

    // j 0x10 from 0xC -> 0x40
    do_instr(32'h0000_000C, 32'h0800_0010, 0, 1'b1, 1'b0, 1'b0, 0, 4'd3);
    // beq imm=FFFE taken at 0x40 -> 0x3C
    do_instr(32'h0000_0040, 32'h1000_FFFE, 1, 1'b0, 1'b1, 1'b1, 0, 4'd4);
    // ALU at 0x3C with a 4-cycle stall -> 0x40
    do_instr(32'h0000_003C, 32'h0232_8020, 0, 1'b0, 1'b0, 1'b0, 4, 4'd5);
    // same beq not taken -> 0x44
    do_instr(32'h0000_0040, 32'h1000_FFFE, 0, 1'b0, 1'b1, 1'b0, 0, 4'd6);
    // j 0x4 from 0x44 -> 0x10
    do_instr(32'h0000_0044, 32'h0800_0004, 0, 1'b1, 1'b0, 1'b0, 0, 4'd7);

    // Maximal forward branches (imm=7FFF) advance pc by 0x20000 each;
    // 2048 of them carry pc from 0x10 up to 0x1000_0010.
    for (int k = 0; k < 2048; k++) begin
      do_instr(32'h0000_0010 + (32'(k) << 17), 32'h1000_7FFF, k % 3,
               1'b0, 1'b1, 1'b1, 0, 4'(8 + k));
    end

    // j 0x0000040 at 0x1000_0010 with branch&zero also set -> 0x1000_0100
    do_instr(32'h1000_0010, 32'h0800_0040, 0, 1'b1, 1'b1, 1'b1, 0, 4'd8);

    // Reset while the fetch at 0x1000_0100 is waiting on the I-cache.
    exp_fetch.push_back(32'h1000_0100);
    icReady = 1'b0;
    repeat (2) begin
      icRdata = $urandom;
      @(negedge clk);
    end
    chk("midfetch_req", {31'h0, icReq}, 32'h1);
    chk("midfetch_addr", icAddr, 32'h1000_0100);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'h0, icReq}, 32'h0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_count", {28'h0, retiredCount}, 32'h0);
    chk("mid_rst_valid", {31'h0, instrValid}, 32'h0);
    @(negedge clk);
    @(negedge clk);

    // Boot again, then retire 17 instructions in total: counter wraps to 1.
    boot(32'h0000_0020);
    for (int k = 1; k < 17; k++) begin
      do_instr(32'(k) << 2, 32'h0000_0020, k % 2, 1'b0, 1'b0, 1'b0, 0, 4'(k));
    end
    chk("count_wrap", {28'h0, retiredCount}, 32'h1);
    exp_fetch.push_back(32'h0000_0044);
    @(negedge clk);
    #2;
    chk("fetch_queue_empty", 32'(exp_fetch.size()), 32'h0);
    chk("exec_queue_empty", 32'(exp_exec.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
